// File: rtl/calc_op_sequencer_pkg.sv
// Shared types and helpers for the calculator operation sequencer and the ALU
// that consumes its requests.
package calc_op_sequencer_pkg;

  localparam int unsigned DEF_WIDTH   = 14;
  localparam int unsigned DEF_MAX_VAL = 9999;

  typedef enum logic [2:0] {
    S_WAIT_A   = 3'd0,
    S_WAIT_OP  = 3'd1,
    S_WAIT_B   = 3'd2,
    S_EXEC     = 3'd3,
    S_WAIT_ACK = 3'd4,
    S_SHOW     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  function automatic logic is_onehot4(input logic [3:0] k);
    return (k != '0) && ((k & (k - 4'd1)) == '0);
  endfunction

  // Only meaningful for one-hot input; anything else decodes to add.
  function automatic op_t onehot_to_op(input logic [3:0] k);
    op_t op;
    case (k)
      4'b0010: op = OP_SUB;
      4'b0100: op = OP_MUL;
      4'b1000: op = OP_DIV;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Request/acknowledge handshake between the sequencer (master) and the
// shared arithmetic unit (slave).
interface calc_op_sequencer_if
  import calc_op_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             alu_req;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_ack;
  logic [WIDTH-1:0] alu_result;
  logic             alu_err;

  modport master (
    output alu_req, alu_op, alu_a, alu_b,
    input  alu_ack, alu_result, alu_err
  );

  modport slave (
    input  alu_req, alu_op, alu_a, alu_b,
    output alu_ack, alu_result, alu_err
  );
endinterface

// File: rtl/calc_op_sequencer_key_edge_detect.sv
// Registered rising-edge detector for level key inputs; the rise output is
// combinational from the live key and the previous-cycle sample.
module key_edge_detect #(
  parameter int unsigned N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] keys,
  output logic [N-1:0] rise
);
  logic [N-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '0;
    else        prev <= keys;
  end

  assign rise = keys & ~prev;
endmodule

// File: rtl/calc_op_sequencer.sv
// Two-operand calculator sequencer: captures A, operator and B from the keypad
// entry path, runs an ALU handshake with timeout and presents result or error.
module calc_op_sequencer
  import calc_op_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned MAX_VAL     = DEF_MAX_VAL,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 num_valid,
  input  logic [WIDTH-1:0]     num_data,
  input  logic [3:0]           op_keys,
  input  logic                 eq_key,
  input  logic                 clr_key,
  calc_op_sequencer_if.master  alu,
  output logic [WIDTH-1:0]     result,
  output logic                 result_valid,
  output logic                 err,
  output logic [2:0]           state_dbg
);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
  localparam int unsigned      CW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(ACK_TIMEOUT);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {EV_NONE, EV_CLR, EV_EQ, EV_OP, EV_NUM} ev_t;

  logic [3:0]       op_rise;
  logic             eq_rise, clr_rise;
  ev_t              ev;
  logic             takes_operand, go_err;
  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             b_valid, req_q, rv_q, err_q;
  logic [CW-1:0]    cnt;

  key_edge_detect #(.N(4)) u_op_edge  (.clk(clk), .rst_n(rst_n), .keys(op_keys), .rise(op_rise));
  key_edge_detect #(.N(1)) u_eq_edge  (.clk(clk), .rst_n(rst_n), .keys(eq_key),  .rise(eq_rise));
  key_edge_detect #(.N(1)) u_clr_edge (.clk(clk), .rst_n(rst_n), .keys(clr_key), .rise(clr_rise));

  // Only the single highest-priority event in a cycle is acted upon.
  always_comb begin
    ev = EV_NONE;
    if (clr_rise)                                 ev = EV_CLR;
    else if (eq_rise)                             ev = EV_EQ;
    else if ((|op_rise) && is_onehot4(op_keys))   ev = EV_OP;
    else if (num_valid)                           ev = EV_NUM;
  end

  assign takes_operand = state inside {S_WAIT_A, S_WAIT_OP, S_WAIT_B, S_SHOW};

  // An ack in the last counted cycle wins over expiry.
  always_comb begin
    go_err = 1'b0;
    if (ev == EV_NUM && takes_operand && num_data > MAX_V) go_err = 1'b1;
    if (state == S_WAIT_ACK) begin
      if (alu.alu_ack) go_err = alu.alu_err || (alu.alu_result > MAX_V);
      else             go_err = (cnt == CNT_ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || ev == EV_CLR) begin
      state   <= S_WAIT_A;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      b_valid <= 1'b0;
      req_q   <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else if (go_err) begin
      state <= S_ERR;
      err_q <= 1'b1;
      res_q <= '0;
      rv_q  <= 1'b0;
      req_q <= 1'b0;
    end else begin
      unique case (state)
        S_WAIT_A: if (ev == EV_NUM) begin
          a_q   <= num_data;
          res_q <= num_data;
          state <= S_WAIT_OP;
        end
        S_WAIT_OP: begin
          if (ev == EV_OP) begin
            op_q    <= onehot_to_op(op_keys);
            b_valid <= 1'b0;
            state   <= S_WAIT_B;
          end else if (ev == EV_NUM) begin
            a_q   <= num_data;
            res_q <= num_data;
          end
        end
        S_WAIT_B: begin
          if (ev == EV_NUM) begin
            b_q     <= num_data;
            res_q   <= num_data;
            b_valid <= 1'b1;
          end else if (ev == EV_OP) begin
            op_q <= onehot_to_op(op_keys);
          end else if (ev == EV_EQ && b_valid) begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          req_q <= 1'b1;
          cnt   <= CNT_LOAD;
          state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (alu.alu_ack) begin
            res_q <= alu.alu_result;
            rv_q  <= 1'b1;
            req_q <= 1'b0;
            state <= S_SHOW;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_SHOW: begin
          if (ev == EV_OP) begin
            a_q     <= res_q;
            op_q    <= onehot_to_op(op_keys);
            rv_q    <= 1'b0;
            b_valid <= 1'b0;
            state   <= S_WAIT_B;
          end else if (ev == EV_NUM) begin
            a_q   <= num_data;
            res_q <= num_data;
            rv_q  <= 1'b0;
            state <= S_WAIT_OP;
          end else if (ev == EV_EQ) begin
            a_q   <= res_q;
            state <= S_EXEC;
          end
        end
        S_ERR: ;
        default: state <= S_WAIT_A;
      endcase
    end
  end

  assign alu.alu_req   = req_q;
  assign alu.alu_op    = op_q;
  assign alu.alu_a     = a_q;
  assign alu.alu_b     = b_q;
  assign result        = res_q;
  assign result_valid  = rv_q;
  assign err           = err_q;
  assign state_dbg     = state;
endmodule
